// File: rtl/match_engine_pkg.sv
// Shared definitions for the match engine return path.
//   - Default geometry (lazy batch length, channel count, field widths).
//   - Merger state encoding.
//   - slot_bits(): index width for a given number of lazy slots.
//   - is_better_match(): candidate ordering (longer wins, then nearer offset),
//     also used by the lazy-evaluation stage.
package match_engine_pkg;

  localparam int DEFAULT_LAZY_LEN        = 4;
  localparam int DEFAULT_NUM_CH          = 4;
  localparam int DEFAULT_SEQ_OFFSET_BITS = 20;
  localparam int DEFAULT_MATCH_LEN_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUTPUT  = 2'd2
  } merge_state_e;

  // A single-slot batch still needs a one-bit slot field.
  function automatic int slot_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when candidate a strictly beats b. Ties return 0 so the caller keeps
  // whichever candidate it already holds.
  function automatic logic is_better_match(
    input logic [DEFAULT_MATCH_LEN_BITS-1:0]  a_len,
    input logic [DEFAULT_SEQ_OFFSET_BITS-1:0] a_offset,
    input logic [DEFAULT_MATCH_LEN_BITS-1:0]  b_len,
    input logic [DEFAULT_SEQ_OFFSET_BITS-1:0] b_offset
  );
    return (a_len > b_len) || ((a_len == b_len) && (a_offset < b_offset));
  endfunction

endpackage

// File: rtl/match_resp_select.sv
// Per-slot winner selection between the current best match and the responses
// accepted for this slot in the current cycle. Purely combinational.
// Ports:
//   inc_len / inc_offset   incumbent (current best) for the slot
//   cand_valid[NUM_CH]     channel j delivered an accepted response for the slot
//   cand_len / cand_offset per-channel response fields, channel j at slice j
//   win_len / win_offset   resulting best for the slot
module match_resp_select
  import match_engine_pkg::*;
#(
  parameter int NUM_CH          = DEFAULT_NUM_CH,
  parameter int SEQ_OFFSET_BITS = DEFAULT_SEQ_OFFSET_BITS,
  parameter int MATCH_LEN_BITS  = DEFAULT_MATCH_LEN_BITS
) (
  input  logic [MATCH_LEN_BITS-1:0]         inc_len,
  input  logic [SEQ_OFFSET_BITS-1:0]        inc_offset,
  input  logic [NUM_CH-1:0]                 cand_valid,
  input  logic [NUM_CH*MATCH_LEN_BITS-1:0]  cand_len,
  input  logic [NUM_CH*SEQ_OFFSET_BITS-1:0] cand_offset,
  output logic [MATCH_LEN_BITS-1:0]         win_len,
  output logic [SEQ_OFFSET_BITS-1:0]        win_offset
);

  // Scanning from the incumbent upward with a strict comparison gives the
  // tie order: incumbent first, then the lowest channel index.
  // A zero-length response never displaces anything, even with a smaller offset.
  always_comb begin
    win_len    = inc_len;
    win_offset = inc_offset;
    for (int j = 0; j < NUM_CH; j++) begin
      if (cand_valid[j] &&
          (cand_len[j*MATCH_LEN_BITS +: MATCH_LEN_BITS] != '0) &&
          is_better_match(cand_len[j*MATCH_LEN_BITS +: MATCH_LEN_BITS],
                          cand_offset[j*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS],
                          win_len, win_offset)) begin
        win_len    = cand_len[j*MATCH_LEN_BITS +: MATCH_LEN_BITS];
        win_offset = cand_offset[j*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS];
      end
    end
  end

endmodule

// File: rtl/match_resp_merger.sv
// Collects per-channel match responses for one lazy batch and merges them into
// one best (length, offset) per lazy slot.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | waiting for a batch route map (req_ready=1)
//   ST_COLLECT | accepting responses until every routed (slot,channel) answered
//   ST_OUTPUT  | merged batch presented on out_*, held until out_ready
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready/req_route_map batch handshake; bit i*NUM_CH+j = slot i on ch j
//   resp_valid/resp_ready            per-channel response handshake
//   resp_slot/resp_len/resp_offset   per-channel response fields
//   out_valid/out_ready              merged batch handshake
//   out_len/out_offset               best length/offset per slot
//   err_unexpected                   sticky: response for a non-pending (slot,ch)
module match_resp_merger
  import match_engine_pkg::*;
#(
  parameter int LAZY_LEN        = DEFAULT_LAZY_LEN,
  parameter int NUM_CH          = DEFAULT_NUM_CH,
  parameter int SEQ_OFFSET_BITS = DEFAULT_SEQ_OFFSET_BITS,
  parameter int MATCH_LEN_BITS  = DEFAULT_MATCH_LEN_BITS,
  parameter int SLOT_BITS       = slot_bits(LAZY_LEN)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [LAZY_LEN*NUM_CH-1:0]          req_route_map,
  input  logic [NUM_CH-1:0]                   resp_valid,
  output logic [NUM_CH-1:0]                   resp_ready,
  input  logic [NUM_CH*SLOT_BITS-1:0]         resp_slot,
  input  logic [NUM_CH*MATCH_LEN_BITS-1:0]    resp_len,
  input  logic [NUM_CH*SEQ_OFFSET_BITS-1:0]   resp_offset,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LAZY_LEN*MATCH_LEN_BITS-1:0]  out_len,
  output logic [LAZY_LEN*SEQ_OFFSET_BITS-1:0] out_offset,
  output logic                                err_unexpected
);

  merge_state_e                 state;
  logic [LAZY_LEN*NUM_CH-1:0]   pending;
  logic [LAZY_LEN*NUM_CH-1:0]   pending_clr;
  logic [LAZY_LEN*NUM_CH-1:0]   pending_next;
  logic [MATCH_LEN_BITS-1:0]    best_len    [LAZY_LEN];
  logic [SEQ_OFFSET_BITS-1:0]   best_offset [LAZY_LEN];
  logic [MATCH_LEN_BITS-1:0]    sel_len     [LAZY_LEN];
  logic [SEQ_OFFSET_BITS-1:0]   sel_offset  [LAZY_LEN];
  logic [NUM_CH-1:0]            cand_valid  [LAZY_LEN];
  logic [SLOT_BITS-1:0]         slot_of     [NUM_CH];
  logic [NUM_CH-1:0]            resp_accept;
  logic [NUM_CH-1:0]            resp_unexp;

  // Outputs decode the state register directly, so they carry no input path.
  assign req_ready  = (state == ST_IDLE);
  assign resp_ready = {NUM_CH{state == ST_COLLECT}};
  assign out_valid  = (state == ST_OUTPUT);

  for (genvar j = 0; j < NUM_CH; j++) begin : g_slot
    assign slot_of[j] = resp_slot[j*SLOT_BITS +: SLOT_BITS];
  end

  // Slot decode is a compare against each legal slot, so an out-of-range slot
  // simply matches nothing and falls into the unexpected path.
  always_comb begin
    pending_clr = '0;
    resp_accept = '0;
    for (int i = 0; i < LAZY_LEN; i++) cand_valid[i] = '0;
    if (state == ST_COLLECT) begin
      for (int j = 0; j < NUM_CH; j++) begin
        for (int i = 0; i < LAZY_LEN; i++) begin
          if (resp_valid[j] && (slot_of[j] == SLOT_BITS'(i)) && pending[i*NUM_CH+j]) begin
            pending_clr[i*NUM_CH+j] = 1'b1;
            cand_valid[i][j]        = 1'b1;
            resp_accept[j]          = 1'b1;
          end
        end
      end
    end
    resp_unexp   = (state == ST_COLLECT) ? (resp_valid & ~resp_accept) : '0;
    pending_next = pending & ~pending_clr;
  end

  for (genvar i = 0; i < LAZY_LEN; i++) begin : g_slot_sel
    match_resp_select #(
      .NUM_CH          (NUM_CH),
      .SEQ_OFFSET_BITS (SEQ_OFFSET_BITS),
      .MATCH_LEN_BITS  (MATCH_LEN_BITS)
    ) u_select (
      .inc_len     (best_len[i]),
      .inc_offset  (best_offset[i]),
      .cand_valid  (cand_valid[i]),
      .cand_len    (resp_len),
      .cand_offset (resp_offset),
      .win_len     (sel_len[i]),
      .win_offset  (sel_offset[i])
    );
    assign out_len[i*MATCH_LEN_BITS +: MATCH_LEN_BITS]     = best_len[i];
    assign out_offset[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS] = best_offset[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pending        <= '0;
      err_unexpected <= 1'b0;
      for (int i = 0; i < LAZY_LEN; i++) begin
        best_len[i]    <= '0;
        best_offset[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pending <= req_route_map;
            for (int i = 0; i < LAZY_LEN; i++) begin
              best_len[i]    <= '0;
              best_offset[i] <= '0;
            end
            // An empty route map has nothing to wait for.
            state <= (req_route_map != '0) ? ST_COLLECT : ST_OUTPUT;
          end
        end
        ST_COLLECT: begin
          pending <= pending_next;
          for (int i = 0; i < LAZY_LEN; i++) begin
            best_len[i]    <= sel_len[i];
            best_offset[i] <= sel_offset[i];
          end
          if (resp_unexp != '0) err_unexpected <= 1'b1;
          if (pending_next == '0) state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_resp_merger.sv
module tb_match_resp_merger;

  localparam int LAZY_LEN = 4;
  localparam int NUM_CH   = 4;
  localparam int OFF_W    = 20;
  localparam int LEN_W    = 8;
  localparam int SLOT_W   = 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         req_valid;
  logic                         req_ready;
  logic [LAZY_LEN*NUM_CH-1:0]   req_route_map;
  logic [NUM_CH-1:0]            resp_valid;
  logic [NUM_CH-1:0]            resp_ready;
  logic [NUM_CH*SLOT_W-1:0]     resp_slot;
  logic [NUM_CH*LEN_W-1:0]      resp_len;
  logic [NUM_CH*OFF_W-1:0]      resp_offset;
  logic                         out_valid;
  logic                         out_ready;
  logic [LAZY_LEN*LEN_W-1:0]    out_len;
  logic [LAZY_LEN*OFF_W-1:0]    out_offset;
  logic                         err_unexpected;

  int n_cmp = 0;
  int n_mis = 0;

  match_resp_merger dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_route_map  (req_route_map),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_slot      (resp_slot),
    .resp_len       (resp_len),
    .resp_offset    (resp_offset),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_len        (out_len),
    .out_offset     (out_offset),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_resp(input int j, input logic [SLOT_W-1:0] s,
                          input logic [LEN_W-1:0] l, input logic [OFF_W-1:0] o);
    resp_valid[j]                = 1'b1;
    resp_slot[j*SLOT_W +: SLOT_W] = s;
    resp_len[j*LEN_W +: LEN_W]    = l;
    resp_offset[j*OFF_W +: OFF_W] = o;
  endtask

  task automatic clear_resp();
    resp_valid  = '0;
    resp_slot   = '0;
    resp_len    = '0;
    resp_offset = '0;
  endtask

  // Present a route map for exactly one cycle (merger must be idle).
  task automatic start_batch(input logic [15:0] map);
    req_valid     = 1'b1;
    req_route_map = map;
    tick();
    req_valid     = 1'b0;
    req_route_map = '0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_route_map = '0; out_ready = 1'b0;
    clear_resp();
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_resp_ready", resp_ready, 4'h0);
    check("rst_err", err_unexpected, 1'b0);
    check("rst_out_len", out_len, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1'b1);

    // Batch 1: slot i -> channel i, one response per cycle
    start_batch(16'h8421);
    check("b1_req_ready", req_ready, 1'b0);
    check("b1_resp_ready", resp_ready, 4'hF);
    set_resp(0, 2'd0, 8'd12, 20'd100); tick(); clear_resp();
    check("b1_not_done0", out_valid, 1'b0);
    set_resp(1, 2'd1, 8'd0, 20'd999); tick(); clear_resp();
    set_resp(2, 2'd2, 8'd7, 20'd5000); tick(); clear_resp();
    check("b1_not_done2", out_valid, 1'b0);
    set_resp(3, 2'd3, 8'd30, 20'd70000); tick(); clear_resp();
    check("b1_out_valid", out_valid, 1'b1);
    check("b1_out_len", out_len, {8'd30, 8'd7, 8'd0, 8'd12});
    check("b1_out_offset", out_offset, {20'd70000, 20'd5000, 20'd0, 20'd100});
    check("b1_resp_ready_out", resp_ready, 4'h0);
    tick();
    check("b1_hold_valid", out_valid, 1'b1);
    check("b1_hold_len", out_len, {8'd30, 8'd7, 8'd0, 8'd12});
    handshake();
    check("b1_idle_out_valid", out_valid, 1'b0);
    check("b1_idle_req_ready", req_ready, 1'b1);
    check("b1_err", err_unexpected, 1'b0);

    // Batch 2: three channels answer slot 0 in one cycle
    start_batch(16'h0007);
    set_resp(0, 2'd0, 8'd10, 20'd300);
    set_resp(1, 2'd0, 8'd10, 20'd200);
    set_resp(2, 2'd0, 8'd9, 20'd50);
    tick(); clear_resp();
    check("b2_out_valid", out_valid, 1'b1);
    check("b2_out_len", out_len, {8'd0, 8'd0, 8'd0, 8'd10});
    check("b2_out_offset", out_offset, {20'd0, 20'd0, 20'd0, 20'd200});
    handshake();

    // Batch 3: empty route map, output held under back-pressure
    start_batch(16'h0000);
    check("b3_out_valid", out_valid, 1'b1);
    check("b3_out_len", out_len, 32'h0);
    check("b3_out_offset", out_offset, 80'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("b3_hold_valid", out_valid, 1'b1);
      check("b3_hold_req_ready", req_ready, 1'b0);
      check("b3_hold_len", out_len, 32'h0);
    end
    handshake();
    check("b3_idle", req_ready, 1'b1);

    // Batch 4: unexpected response mid-batch
    start_batch(16'h8421);
    set_resp(0, 2'd0, 8'd5, 20'd9);
    set_resp(3, 2'd0, 8'd50, 20'd1);
    tick(); clear_resp();
    check("b4_err_set", err_unexpected, 1'b1);
    check("b4_still_collect", out_valid, 1'b0);
    set_resp(1, 2'd1, 8'd3, 20'd11);
    set_resp(2, 2'd2, 8'd4, 20'd12);
    set_resp(3, 2'd3, 8'd6, 20'd13);
    tick(); clear_resp();
    check("b4_out_valid", out_valid, 1'b1);
    check("b4_out_len", out_len, {8'd6, 8'd4, 8'd3, 8'd5});
    check("b4_out_offset", out_offset, {20'd13, 20'd12, 20'd11, 20'd9});
    handshake();
    check("b4_err_sticky", err_unexpected, 1'b1);

    // Batch 5: reset while two responses are still outstanding
    start_batch(16'h8421);
    set_resp(0, 2'd0, 8'd20, 20'd7);
    set_resp(1, 2'd1, 8'd21, 20'd8);
    tick(); clear_resp();
    check("b5_collecting", out_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("b5_rst_out_valid", out_valid, 1'b0);
    check("b5_rst_req_ready", req_ready, 1'b1);
    check("b5_rst_err", err_unexpected, 1'b0);
    start_batch(16'h0021);
    set_resp(0, 2'd0, 8'd3, 20'd40);
    set_resp(1, 2'd1, 8'd0, 20'd0);
    tick(); clear_resp();
    check("b5_out_valid", out_valid, 1'b1);
    check("b5_out_len", out_len, {8'd0, 8'd0, 8'd0, 8'd3});
    check("b5_out_offset", out_offset, {20'd0, 20'd0, 20'd0, 20'd40});
    handshake();

    // Batch 6/7: back-to-back with out_ready held high
    start_batch(16'h0001);
    set_resp(0, 2'd0, 8'd100, 20'd1000);
    tick(); clear_resp();
    check("b6_out_valid", out_valid, 1'b1);
    check("b6_out_len", out_len, {8'd0, 8'd0, 8'd0, 8'd100});
    out_ready     = 1'b1;
    req_valid     = 1'b1;
    req_route_map = 16'h0010;
    tick();
    check("b6_hs_out_valid", out_valid, 1'b0);
    check("b6_hs_req_ready", req_ready, 1'b1);
    tick();
    req_valid     = 1'b0;
    req_route_map = '0;
    check("b7_accepted", req_ready, 1'b0);
    check("b7_resp_ready", resp_ready, 4'hF);
    set_resp(0, 2'd1, 8'd2, 20'd77);
    tick(); clear_resp();
    check("b7_out_valid", out_valid, 1'b1);
    check("b7_out_len", out_len, {8'd0, 8'd0, 8'd2, 8'd0});
    check("b7_out_offset", out_offset, {20'd0, 20'd0, 20'd77, 20'd0});
    tick();
    out_ready = 1'b0;
    check("b7_idle", req_ready, 1'b1);
    check("b7_err", err_unexpected, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
